// File: rtl/request_latch.sv
// ============================================================================
// Module   : request_latch
// Brief    : Synchronizes, debounces and latches four raw request lines into
//            a pending-request vector for the 4-input priority encoder.
//            Optional overflow flags are built when REQ_LATCH_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_latch #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       en_in,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       clr_ovf,
    output logic [3:0] Is,
    output logic       Ein,
    output logic [3:0] ovf
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_s1;
    logic [3:0]       r_s2;
    logic [3:0]       r_db;
    logic [3:0]       r_db_d;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_is;
    logic             r_ein;

    logic [3:0]       w_rise;
    logic [3:0]       w_clr;
    logic [3:0]       w_is_nxt;

    assign w_rise = r_db & ~r_db_d;

    always_comb begin
        w_clr = 4'b0000;
        if (ack) begin
            w_clr[ack_idx] = 1'b1;
        end
    end

    // A new debounced edge outranks a same-cycle ack so no event is lost.
    assign w_is_nxt = w_rise | (r_is & ~w_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 4'b0000;
            r_s2   <= 4'b0000;
            r_db   <= 4'b0000;
            r_db_d <= 4'b0000;
            r_is   <= 4'b0000;
            r_ein  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= req_in;
            r_s2   <= r_s1;
            r_db_d <= r_db;
            r_is   <= w_is_nxt;
            r_ein  <= en_in;
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_cnt_max) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign Is  = r_is;
    assign Ein = r_ein;

`ifdef REQ_LATCH_OVF_EN
    logic [3:0] r_ovf;
    logic [3:0] w_ovf_set;

    // An edge merged into a request the consumer has not yet serviced.
    assign w_ovf_set = w_rise & r_is & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 4'b0000;
        end else if (clr_ovf) begin
            r_ovf <= w_ovf_set;
        end else begin
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_clr_ovf;
    assign w_unused_clr_ovf = clr_ovf;
    assign ovf              = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_request_latch.sv
// ============================================================================
// Module   : tb_request_latch
// Brief    : Directed self-checking bench for request_latch (DEBOUNCE_CYCLES=4)
//            with an expected-value queue; honours REQ_LATCH_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic       en_in;
    logic       ack;
    logic [1:0] ack_idx;
    logic       clr_ovf;
    logic [3:0] Is;
    logic       Ein;
    logic [3:0] ovf;

    typedef struct packed {
        logic [3:0] is;
        logic       ein;
        logic [3:0] ovf;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    request_latch #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .en_in  (en_in),
        .ack    (ack),
        .ack_idx(ack_idx),
        .clr_ovf(clr_ovf),
        .Is     (Is),
        .Ein    (Ein),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ov(input logic [3:0] v);
`ifdef REQ_LATCH_OVF_EN
        return v;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] is,
                            input logic ein, input logic [3:0] o);
        exp_t e;
        e.is  = is;
        e.ein = ein;
        e.ovf = o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic chk();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed=empty queue expected=entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (Is === e.is) else begin
            errors++;
            $error("FAIL %s Is: observed=%b expected=%b", t, Is, e.is);
        end
        checks++;
        assert (Ein === e.ein) else begin
            errors++;
            $error("FAIL %s Ein: observed=%b expected=%b", t, Ein, e.ein);
        end
        checks++;
        assert (ovf === e.ovf) else begin
            errors++;
            $error("FAIL %s ovf: observed=%b expected=%b", t, ovf, e.ovf);
        end
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        tick(1);
        ack     = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_in  = 4'b0000;
        en_in   = 1'b0;
        ack     = 1'b0;
        ack_idx = 2'd0;
        clr_ovf = 1'b0;

        push_exp("reset", 4'b0000, 1'b0, 4'b0000);
        tick(2);
        chk();

        rst_n = 1'b1;
        en_in = 1'b1;
        push_exp("ein_follow", 4'b0000, 1'b1, 4'b0000);
        tick(1);
        chk();

        // Latency: req_in[2] rises, first sampled at edge E
        req_in = 4'b0100;
        tick(1);
        push_exp("lat_e4", 4'b0000, 1'b1, 4'b0000);
        tick(4);
        chk();
        push_exp("lat_e5", 4'b0000, 1'b1, 4'b0000);
        tick(1);
        chk();
        push_exp("lat_e6", 4'b0100, 1'b1, 4'b0000);
        tick(1);
        chk();

        req_in = 4'b0000;
        push_exp("fall_hold", 4'b0100, 1'b1, 4'b0000);
        tick(8);
        chk();

        push_exp("ack_bit2", 4'b0000, 1'b1, 4'b0000);
        do_ack(2'd2);
        chk();

        req_in = 4'b1001;
        push_exp("press_1001", 4'b1001, 1'b1, 4'b0000);
        tick(8);
        chk();
        req_in = 4'b0000;
        tick(8);

        push_exp("ack_idx3", 4'b0001, 1'b1, 4'b0000);
        do_ack(2'd3);
        chk();
        push_exp("ack_not_pending", 4'b0001, 1'b1, 4'b0000);
        do_ack(2'd2);
        chk();

        // Bounce on bit 1: never stable for 4 cycles
        req_in = 4'b0010;
        tick(3);
        req_in = 4'b0000;
        tick(1);
        req_in = 4'b0010;
        push_exp("bounce_mid", 4'b0001, 1'b1, 4'b0000);
        tick(3);
        chk();
        req_in = 4'b0000;
        push_exp("bounce_end", 4'b0001, 1'b1, 4'b0000);
        tick(10);
        chk();

        // Set wins: rise[0] coincides with ack of bit 0 while Is[0]=1
        req_in = 4'b0001;
        tick(6);
        push_exp("set_wins", 4'b0001, 1'b1, 4'b0000);
        do_ack(2'd0);
        chk();
        push_exp("set_wins_hold", 4'b0001, 1'b1, 4'b0000);
        tick(1);
        chk();
        req_in = 4'b0000;
        tick(8);
        do_ack(2'd0);

        // Overflow: second press on bit 3 with no ack
        req_in = 4'b1000;
        tick(8);
        req_in = 4'b0000;
        tick(8);
        req_in = 4'b1000;
        push_exp("ovf_set", 4'b1000, 1'b1, ov(4'b1000));
        tick(8);
        chk();
        req_in = 4'b0000;
        push_exp("ovf_sticky", 4'b1000, 1'b1, ov(4'b1000));
        tick(8);
        chk();
        clr_ovf = 1'b1;
        push_exp("ovf_clear", 4'b1000, 1'b1, 4'b0000);
        tick(1);
        clr_ovf = 1'b0;
        chk();
        do_ack(2'd3);

        // Build Is=1010, ovf=0010, then reset asynchronously mid-cycle
        req_in = 4'b1010;
        tick(8);
        req_in = 4'b0000;
        tick(8);
        req_in = 4'b0010;
        push_exp("pre_reset", 4'b1010, 1'b1, ov(4'b0010));
        tick(8);
        chk();
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 4'b0000, 1'b0, 4'b0000);
        chk();

        // Release with req_in[1] still high: latched as a new request
        tick(2);
        rst_n = 1'b1;
        push_exp("powerup_req", 4'b0010, 1'b1, 4'b0000);
        tick(10);
        chk();

        en_in = 1'b0;
        push_exp("ein_low", 4'b0010, 1'b0, 4'b0000);
        tick(1);
        chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
